// File: rtl/spi16_master.sv
// SPI mode-0 master that shifts one 16-bit word MSB first with programmable SCLK
// half-period, chip-select setup/hold and inter-frame gap.
module spi16_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 2
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        start,
    input  logic [15:0] tx_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_data,
    output logic        nCS,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } state_t;

    // Every timed state counts 0..LEN-1 and leaves on the last count.
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [4:0]  bit_cnt, bit_n;
    logic [15:0] tx_lat, tx_lat_n;
    logic [15:0] rx_sh, rx_sh_n;
    logic [15:0] rx_data_n;
    logic        busy_n, done_n, ncs_n, sclk_n, mosi_n;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state   <= ST_IDLE;
            cnt     <= 8'd0;
            bit_cnt <= 5'd0;
            tx_lat  <= 16'h0000;
            rx_sh   <= 16'h0000;
            rx_data <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b0;
            nCS     <= 1'b1;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            tx_lat  <= tx_lat_n;
            rx_sh   <= rx_sh_n;
            rx_data <= rx_data_n;
            busy    <= busy_n;
            done    <= done_n;
            nCS     <= ncs_n;
            SCLK    <= sclk_n;
            MOSI    <= mosi_n;
        end
    end

    // Outputs are computed one cycle ahead so that every port comes straight from a flop.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 8'd1;
        bit_n     = bit_cnt;
        tx_lat_n  = tx_lat;
        rx_sh_n   = rx_sh;
        rx_data_n = rx_data;
        busy_n    = busy;
        done_n    = 1'b0;
        ncs_n     = nCS;
        sclk_n    = SCLK;
        mosi_n    = MOSI;

        case (state)
            ST_IDLE: begin
                cnt_n = 8'd0;
                if (start) begin
                    tx_lat_n = tx_data;
                    rx_sh_n  = 16'h0000;
                    bit_n    = 5'd0;
                    mosi_n   = tx_data[15];
                    ncs_n    = 1'b0;
                    busy_n   = 1'b1;
                    state_n  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n   = 8'd0;
                    state_n = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (cnt == DIV_LAST) begin
                    cnt_n   = 8'd0;
                    sclk_n  = 1'b1;
                    rx_sh_n = {rx_sh[14:0], MISO};
                    state_n = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (cnt == DIV_LAST) begin
                    cnt_n  = 8'd0;
                    sclk_n = 1'b0;
                    if (bit_cnt == 5'd15) begin
                        mosi_n  = 1'b0;
                        state_n = ST_HOLD;
                    end else begin
                        bit_n   = bit_cnt + 5'd1;
                        // Bit k of the frame is tx_lat[15-k]; for a 4-bit index 15-k == ~k.
                        mosi_n  = tx_lat[~bit_n[3:0]];
                        state_n = ST_SHIFT_LO;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n   = 8'd0;
                    ncs_n   = 1'b1;
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n     = 8'd0;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    rx_data_n = rx_sh;
                    state_n   = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_n   = 8'd0;
                state_n = ST_IDLE;
            end
            default: begin
                cnt_n   = 8'd0;
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi16_master.sv
// Bench for spi16_master: table-driven and random frames against a frame-level
// reference model, plus back-to-back, ignored-start and mid-frame reset sequences.
module tb_spi16_master;

    localparam int CLK_DIV_D  = 4;
    localparam int CS_SETUP_D = 2;
    localparam int CS_HOLD_D  = 2;
    localparam int GAP_D      = 2;
    localparam int GAP_F      = 1;
    localparam int NCS_LOW_F  = 1 + 32 * 1 + 1;

    logic        clk = 1'b0;
    logic        res_n;
    logic        start;
    logic [15:0] tx_data;
    logic        busy, done, nCS, SCLK, MOSI, MISO;
    logic [15:0] rx_data;
    logic        loop_en, miso_drv;

    logic        start_f;
    logic [15:0] tx_f;
    logic        busy_f, done_f, ncs_f, sclk_f, mosi_f;
    logic [15:0] rx_f;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign MISO = loop_en ? MOSI : miso_drv;

    spi16_master dut (
        .clk(clk), .res_n(res_n), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .nCS(nCS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
    );

    spi16_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GAP(GAP_F)) dut_fast (
        .clk(clk), .res_n(res_n), .start(start_f), .tx_data(tx_f),
        .busy(busy_f), .done(done_f), .rx_data(rx_f),
        .nCS(ncs_f), .SCLK(sclk_f), .MOSI(mosi_f), .MISO(mosi_f)
    );

    typedef struct {
        logic [15:0] tx;
        bit          loop;
        logic [15:0] mword;
        bit          scramble;
        int          repulse;
        logic [15:0] exp_rx;
    } vec_t;

    typedef struct {
        bit          timed_out;
        int          dones;
        int          latency;
        int          ncs_low;
        int          rises;
        logic [15:0] mosi_bits;
        logic [15:0] rx;
        logic        mosi_end;
        logic        busy_at_done;
        int          viol;
        int          trailing;
    } frame_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic waitIdle();
        int w = 0;
        while ((busy || done) && w < 300) begin
            @(negedge clk);
            w++;
        end
    endtask

    // Runs one frame on the default instance and records what was observed on the pins.
    task automatic applyStimulus(input logic [15:0] tx, input bit loop, input logic [15:0] mword,
                                 input bit scramble, input int repulse, output frame_t r);
        logic prev_sclk, prev_ncs;
        r.timed_out = 1'b1; r.dones = 0; r.latency = -1; r.ncs_low = 0; r.rises = 0;
        r.mosi_bits = 16'h0; r.rx = 16'h0; r.mosi_end = 1'b1; r.busy_at_done = 1'b1;
        r.viol = 0; r.trailing = 0;
        waitIdle();
        @(negedge clk);
        loop_en  = loop;
        miso_drv = mword[15];
        tx_data  = tx;
        start    = 1'b1;
        prev_sclk = SCLK;
        prev_ncs  = nCS;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
            if (scramble) tx_data = 16'($urandom);
            if (repulse != 0 && t == repulse) begin
                start   = 1'b1;
                tx_data = ~tx;
            end
            if (repulse != 0 && t == repulse + 1) start = 1'b0;
            if (!nCS) r.ncs_low++;
            if (SCLK && !prev_sclk) begin
                r.rises++;
                r.mosi_bits = {r.mosi_bits[14:0], MOSI};
            end
            if ((SCLK != prev_sclk) && (nCS != prev_ncs)) r.viol++;
            if (SCLK && nCS) r.viol++;
            prev_sclk = SCLK;
            prev_ncs  = nCS;
            miso_drv  = (r.rises < 16) ? mword[4'(15 - r.rises)] : 1'b0;
            if (done) begin
                r.dones++;
                r.latency      = t;
                r.rx           = rx_data;
                r.mosi_end     = MOSI;
                r.busy_at_done = busy;
                r.timed_out    = 1'b0;
                break;
            end
        end
        start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (busy || done || !nCS || SCLK) r.trailing++;
        end
    endtask

    // Reference model: a frame is judged only by its externally visible totals.
    task automatic checkFrame(input string tag, input frame_t r, input logic [15:0] tx, input logic [15:0] exp_rx);
        int exp_low = CS_SETUP_D + 32 * CLK_DIV_D + CS_HOLD_D;
        int exp_lat = exp_low + GAP_D;
        checkOutput({tag, ".timeout"}, 32'(r.timed_out), 32'd0);
        checkOutput({tag, ".latency"}, r.latency, exp_lat);
        checkOutput({tag, ".ncs_low"}, r.ncs_low, exp_low);
        checkOutput({tag, ".rises"}, r.rises, 16);
        checkOutput({tag, ".mosi_bits"}, 32'(r.mosi_bits), 32'(tx));
        checkOutput({tag, ".rx_data"}, 32'(r.rx), 32'(exp_rx));
        checkOutput({tag, ".mosi_end"}, 32'(r.mosi_end), 32'd0);
        checkOutput({tag, ".busy_at_done"}, 32'(r.busy_at_done), 32'd0);
        checkOutput({tag, ".pin_rules"}, r.viol, 0);
        checkOutput({tag, ".after_done"}, r.trailing, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t   vecs[$];
        frame_t r;
        logic [15:0] rtx, rmw, rexp;
        bit     rlp, rsc;
        int     dones, run, rises;
        int     lows[$], highs[$];
        logic   prev, prev_sclk;
        bit     seen_low;

        vecs.push_back('{16'hA5C3, 1'b1, 16'h0000, 1'b0, 0,  16'hA5C3});
        vecs.push_back('{16'h0000, 1'b0, 16'hFFFF, 1'b0, 0,  16'hFFFF});
        vecs.push_back('{16'hFFFF, 1'b0, 16'h0000, 1'b0, 0,  16'h0000});
        vecs.push_back('{16'h3C5A, 1'b0, 16'h8001, 1'b0, 0,  16'h8001});
        vecs.push_back('{16'hA5C3, 1'b1, 16'h0000, 1'b0, 10, 16'hA5C3});
        vecs.push_back('{16'h6E91, 1'b1, 16'h0000, 1'b1, 0,  16'h6E91});

        res_n = 1'b0; start = 1'b0; tx_data = 16'h0; loop_en = 1'b0; miso_drv = 1'b0;
        start_f = 1'b0; tx_f = 16'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset.nCS", 32'(nCS), 32'd1);
        checkOutput("reset.SCLK", 32'(SCLK), 32'd0);
        checkOutput("reset.MOSI", 32'(MOSI), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.rx_data", 32'(rx_data), 32'd0);
        res_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].tx, vecs[i].loop, vecs[i].mword, vecs[i].scramble, vecs[i].repulse, r);
            checkFrame($sformatf("vec%0d", i), r, vecs[i].tx, vecs[i].exp_rx);
        end

        for (int i = 0; i < 6; i++) begin
            rtx  = 16'($urandom);
            rmw  = 16'($urandom);
            rlp  = 1'($urandom_range(0, 1));
            rsc  = 1'($urandom_range(0, 1));
            rexp = rlp ? rtx : rmw;
            applyStimulus(rtx, rlp, rmw, rsc, 0, r);
            checkFrame($sformatf("rand%0d", i), r, rtx, rexp);
        end

        // A start raised during the done cycle must not open a new frame.
        waitIdle();
        @(negedge clk);
        loop_en = 1'b1; tx_data = 16'h0F0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int t = 0; t < 300 && dones == 0; t++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("done_start.done_seen", dones, 1);
        start = 1'b1; tx_data = 16'hF0F0;
        @(negedge clk);
        checkOutput("done_start.busy", 32'(busy), 32'd0);
        start = 1'b0;
        @(negedge clk);
        checkOutput("done_start.nCS", 32'(nCS), 32'd1);

        // Reset at the seventh SCLK rising edge aborts the frame silently.
        waitIdle();
        @(negedge clk);
        loop_en = 1'b1; tx_data = 16'hBEEF; start = 1'b1;
        prev_sclk = 1'b0; rises = 0;
        for (int t = 0; t < 300 && rises < 7; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (SCLK && !prev_sclk) rises++;
            prev_sclk = SCLK;
        end
        checkOutput("rst.edge7_reached", rises, 7);
        res_n = 1'b0;
        #1;
        checkOutput("rst.nCS", 32'(nCS), 32'd1);
        checkOutput("rst.SCLK", 32'(SCLK), 32'd0);
        checkOutput("rst.MOSI", 32'(MOSI), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.rx_data", 32'(rx_data), 32'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        res_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checkOutput("rst.no_done", dones, 0);
        applyStimulus(16'h1234, 1'b1, 16'h0000, 1'b0, 0, r);
        checkFrame("after_rst", r, 16'h1234, 16'h1234);

        // Minimum-timing instance with start held high for three frames.
        @(negedge clk);
        tx_f = 16'h5A3C; start_f = 1'b1;
        prev = ncs_f; run = 1; seen_low = 1'b0; dones = 0;
        for (int t = 0; t < 300 && dones < 3; t++) begin
            @(negedge clk);
            if (ncs_f == prev) run++;
            else begin
                if (!prev) begin
                    lows.push_back(run);
                    seen_low = 1'b1;
                end else if (seen_low) highs.push_back(run);
                run  = 1;
                prev = ncs_f;
            end
            if (done_f) begin
                dones++;
                checkOutput($sformatf("fast.rx%0d", dones), 32'(rx_f), 32'h5A3C);
                if (dones == 3) start_f = 1'b0;
            end
        end
        checkOutput("fast.dones", dones, 3);
        checkOutput("fast.low_runs", lows.size(), 3);
        checkOutput("fast.high_runs", highs.size(), 2);
        foreach (lows[i]) checkOutput($sformatf("fast.low%0d", i), lows[i], NCS_LOW_F);
        foreach (highs[i]) checkOutput($sformatf("fast.high%0d", i), highs[i], GAP_F + 2);
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_f || busy_f) dones++;
        end
        checkOutput("fast.stopped", dones, 0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi16_master.md
SPI16_MASTER -- requirements
Module: spi16_master

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter CS_SETUP, default 2: clk cycles with nCS low and SCLK low before the first SCLK rising edge; legal range 1..255.
REQ-003 Parameter CS_HOLD, default 2: clk cycles with nCS low after the last SCLK falling edge; legal range 1..255.
REQ-004 Parameter GAP, default 2: minimum clk cycles with nCS high between frames; legal range 1..255.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 res_n  input  1  reset, asynchronous assert and active-low.
REQ-007 start  input  1  request one frame; sampled only while busy=0.
REQ-008 tx_data  input  16  frame to transmit, MSB first; latched in the accept cycle.
REQ-009 busy  output  1  high from the cycle after accept until the done cycle, exclusive of the done cycle.
REQ-010 done  output  1  one-cycle pulse at frame end.
REQ-011 rx_data  output  16  word received on MISO; updated only in the done cycle, and held otherwise.
REQ-012 nCS  output  1  slave select, active low.
REQ-013 SCLK  output  1  SPI clock, mode 0 (idle low).
REQ-014 MOSI  output  1  serial data out.
REQ-015 MISO  input  1  serial data in.

Function
REQ-016 Every output SHALL be registered. The FSM states SHALL be IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP and DONE.
REQ-017 In IDLE with start=1, the block SHALL latch tx_data, drive nCS low and MOSI=tx_data[15] on the next edge, and enter SETUP.
REQ-018 SETUP SHALL last CS_SETUP cycles with SCLK=0, then move to SHIFT_LO.
REQ-019 Each of the 16 bits SHALL consist of SHIFT_LO (CLK_DIV cycles, SCLK=0, MOSI stable) followed by SHIFT_HI (CLK_DIV cycles, SCLK=1).
REQ-020 MISO SHALL be captured into the shift register on the clk edge that drives SCLK high. Capture SHALL be MSB first, so the first captured bit becomes rx_data[15].
REQ-021 MOSI SHALL advance to the next bit on the edge that drives SCLK low. After the 16th falling edge, MOSI SHALL be 0.
REQ-022 A 5-bit bit counter SHALL count 0..15. After bit 15 the FSM SHALL go to HOLD, with no wrap to a 17th bit.
REQ-023 HOLD SHALL last CS_HOLD cycles with nCS low and SCLK low. nCS SHALL then rise, and the FSM SHALL enter GAP.
REQ-024 GAP SHALL last GAP cycles with nCS high and busy high. DONE SHALL then assert done=1 for one cycle, load rx_data, set busy=0, and return to IDLE.
REQ-025 nCS SHALL be low for exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles per frame. With defaults this is 132 cycles.
REQ-026 Latency from the accept edge to the done cycle SHALL be CS_SETUP + 32*CLK_DIV + CS_HOLD + GAP cycles. With defaults this is 134 cycles.
REQ-027 A start while busy=1 SHALL be ignored and not queued.
REQ-028 A start in the done cycle SHALL be ignored.
REQ-029 With start held high, frames SHALL run back to back. nCS SHALL be high for GAP+2 cycles between frames.
REQ-030 Changes on tx_data after accept SHALL NOT affect the frame in flight.
REQ-031 SCLK SHALL never toggle while nCS is high.
REQ-032 nCS SHALL never change in the same cycle as an SCLK edge.

Reset
REQ-033 With res_n=0, immediately and independent of clk: nCS=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=16'h0000, FSM in IDLE, all counters 0.
REQ-034 Reset mid-frame SHALL abort the frame with no done pulse. After release, the first accepted start SHALL produce a complete, correct frame.

Verification
REQ-035 Defaults, tx_data=16'hA5C3, loopback MISO=MOSI: nCS low 132 cycles, exactly 16 SCLK rising edges, MOSI bits 1010010111000011, done 134 cycles after accept, rx_data=16'hA5C3.
REQ-036 MISO tied 1, tx_data=16'h0000: rx_data=16'hFFFF. With MISO tied 0: rx_data=16'h0000.
REQ-037 CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, GAP=1, start held high for 3 frames: 3 done pulses, each frame's nCS low for 34 cycles, nCS high for 3 cycles between frames.
REQ-038 Pulse start again 10 cycles into a frame with a different tx_data: ignored; the frame completes with the original data and only one done pulse.
REQ-039 Assert res_n=0 at SCLK edge 7: nCS=1 and SCLK=0 within the same cycle, no done pulse. A new frame of 16'h1234 after release completes correctly.
REQ-040 Change tx_data every cycle during a frame: the transmitted bits equal the value latched at accept.
